// File: rtl/clk_strobe_gen.sv
// PLL-lock reset sequencer plus per-channel phase-accumulator strobe generator.
// Optional lock-loss event counter is enabled by defining CLK_STROBE_GEN_LOSS_COUNT_EN.
module clk_strobe_gen #(
  parameter int  NUM_CH     = 2,
  parameter int  ACC_W      = 16,
  parameter int  LOCK_DELAY = 1024,
  parameter int  INC_INIT   = 4096,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pll_lock,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  output logic [NUM_CH-1:0] strobe,
  output logic              rst_out_n,
  output logic              locked
`ifdef CLK_STROBE_GEN_LOSS_COUNT_EN
  ,
  output logic [7:0]        lost_cnt
`endif
);
  localparam int CNT_W = $clog2(LOCK_DELAY);

  typedef enum logic [1:0] {S_WAIT_LOCK, S_STABLE, S_RUN} state_t;

  logic [1:0]                   r_sync;
  logic                         w_lock_s;
  state_t                       r_state, w_state_nxt;
  logic [CNT_W-1:0]             r_cnt, w_cnt_nxt;
  logic                         r_locked, r_rst_n;
  logic [NUM_CH-1:0][ACC_W-1:0] r_acc, r_inc;
  logic [NUM_CH-1:0][ACC_W:0]   w_sum;
  logic [NUM_CH-1:0]            r_strobe;
  logic                         w_acc_en, w_ch_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sync <= 2'b00;
    else          r_sync <= {r_sync[0], pll_lock};
  end
  assign w_lock_s = r_sync[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_WAIT_LOCK;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // RUN is entered on the edge where the count would reach LOCK_DELAY-1,
  // giving exactly LOCK_DELAY edges of lock_s high before release.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    case (r_state)
      S_WAIT_LOCK: if (w_lock_s) w_state_nxt = S_STABLE;
      S_STABLE: begin
        if (!w_lock_s)                             w_state_nxt = S_WAIT_LOCK;
        else if (r_cnt == CNT_W'(LOCK_DELAY - 2))  w_state_nxt = S_RUN;
        else                                       w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
      S_RUN:       if (!w_lock_s) w_state_nxt = S_WAIT_LOCK;
      default:     w_state_nxt = S_WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_locked <= 1'b0;
      r_rst_n  <= 1'b0;
    end else begin
      r_locked <= (w_state_nxt == S_RUN);
      r_rst_n  <= (w_state_nxt == S_RUN);
    end
  end

  // Accumulate only while staying in RUN so a lock loss clears strobes in the same edge.
  assign w_acc_en = (r_state == S_RUN) && w_lock_s;

  always_comb begin
    for (int g = 0; g < NUM_CH; g++)
      w_sum[g] = {1'b0, r_acc[g]} + {1'b0, r_inc[g]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc    <= '0;
      r_strobe <= '0;
    end else if (w_acc_en) begin
      for (int g = 0; g < NUM_CH; g++) begin
        r_acc[g]    <= w_sum[g][ACC_W-1:0];
        r_strobe[g] <= w_sum[g][ACC_W];
      end
    end else begin
      r_acc    <= '0;
      r_strobe <= '0;
    end
  end

  assign w_ch_ok = (int'(cfg_ch) < NUM_CH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                r_inc         <= {NUM_CH{ACC_W'(INC_INIT)}};
    else if (cfg_we && w_ch_ok)  r_inc[cfg_ch] <= cfg_inc;
  end

`ifdef CLK_STROBE_GEN_LOSS_COUNT_EN
  logic [7:0] r_lost;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_lost <= 8'd0;
    else if ((r_state == S_RUN) && (w_state_nxt == S_WAIT_LOCK) && (r_lost != 8'hFF))
      r_lost <= r_lost + 8'd1;
  end
  assign lost_cnt = r_lost;
`endif

  assign strobe    = r_strobe;
  assign locked    = r_locked;
  assign rst_out_n = r_rst_n;

endmodule

// File: tb/tb_clk_strobe_gen.sv
// Self-checking bench for clk_strobe_gen: lock release, rates, glitch, loss, writes, reset.
// Reference model tracks lock as a run length of synchronised-high cycles.
module tb_clk_strobe_gen;
  localparam int NUM_CH   = 3;
  localparam int ACC_W    = 16;
  localparam int LD       = 1024;
  localparam int INC_INIT = 4096;
  localparam int CH_W     = 2;
  localparam int MOD      = 1 << ACC_W;

  logic              clk      = 1'b0;
  logic              reset_n  = 1'b0;
  logic              pll_lock = 1'b0;
  logic              cfg_we   = 1'b0;
  logic [CH_W-1:0]   cfg_ch   = '0;
  logic [ACC_W-1:0]  cfg_inc  = '0;
  logic [NUM_CH-1:0] strobe;
  logic              rst_out_n, locked;
`ifdef CLK_STROBE_GEN_LOSS_COUNT_EN
  logic [7:0]        lost_cnt;
  logic              lock2 = 1'b0;
  logic [0:0]        stb2;
  logic              rst2, locked2;
  logic [7:0]        lost2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clk_strobe_gen #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .LOCK_DELAY(LD), .INC_INIT(INC_INIT)) u_dut (
    .clk(clk), .reset_n(reset_n), .pll_lock(pll_lock), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_inc(cfg_inc), .strobe(strobe), .rst_out_n(rst_out_n), .locked(locked)
`ifdef CLK_STROBE_GEN_LOSS_COUNT_EN
    , .lost_cnt(lost_cnt)
`endif
  );

`ifdef CLK_STROBE_GEN_LOSS_COUNT_EN
  // Short-delay instance so hundreds of loss events fit in a short run.
  clk_strobe_gen #(.NUM_CH(1), .ACC_W(8), .LOCK_DELAY(2), .INC_INIT(1)) u_sat (
    .clk(clk), .reset_n(reset_n), .pll_lock(lock2), .cfg_we(1'b0), .cfg_ch(1'b0),
    .cfg_inc(8'h00), .strobe(stb2), .rst_out_n(rst2), .locked(locked2), .lost_cnt(lost2)
  );
`endif

  // Reference model: locked iff synchronised lock has been high for >= LD edges.
  int                cyc;
  logic              p1, p2;
  int                run_len;
  logic              e_locked;
  logic [NUM_CH-1:0] e_strobe;
  int                m_acc [NUM_CH];
  int                m_inc [NUM_CH];
  int                e_lost;
  int                n_run_len, n_lost, s_t;
  logic              n_locked;
  logic [NUM_CH-1:0] n_strobe;
  int                n_acc [NUM_CH];
  int                n_inc [NUM_CH];

  always_comb begin
    n_run_len = p2 ? ((run_len < LD) ? run_len + 1 : run_len) : 0;
    n_locked  = (n_run_len >= LD);
    n_strobe  = '0;
    n_lost    = e_lost;
    s_t       = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      n_acc[i] = 0;
      n_inc[i] = m_inc[i];
      if (e_locked && n_locked) begin
        s_t         = m_acc[i] + m_inc[i];
        n_strobe[i] = (s_t >= MOD);
        n_acc[i]    = s_t % MOD;
      end
    end
    if (e_locked && !n_locked && e_lost < 255) n_lost = e_lost + 1;
    if (cfg_we && int'(cfg_ch) < NUM_CH) n_inc[int'(cfg_ch)] = int'(cfg_inc);
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc <= 0; p1 <= 1'b0; p2 <= 1'b0; run_len <= 0;
      e_locked <= 1'b0; e_strobe <= '0; e_lost <= 0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_acc[i] <= 0;
        m_inc[i] <= INC_INIT;
      end
    end else begin
      cyc <= cyc + 1; p1 <= pll_lock; p2 <= p1; run_len <= n_run_len;
      e_locked <= n_locked; e_strobe <= n_strobe; e_lost <= n_lost;
      for (int i = 0; i < NUM_CH; i++) begin
        m_acc[i] <= n_acc[i];
        m_inc[i] <= n_inc[i];
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; pll_lock = 1'b0; cfg_we = 1'b0;
    tick(3);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", locked); end
    checks++; if (rst_out_n !== 1'b0) begin errors++; $display("FAIL reset_rst_out_n: got %b expected 0", rst_out_n); end
    checks++; if (strobe !== '0) begin errors++; $display("FAIL reset_strobe: got %b expected 0", strobe); end
`ifdef CLK_STROBE_GEN_LOSS_COUNT_EN
    checks++; if (lost_cnt !== 8'd0) begin errors++; $display("FAIL reset_lost_cnt: got %0d expected 0", lost_cnt); end
`endif
    reset_n = 1'b1;
  endtask

  task automatic test_lock_release();
    int rise = -1, first = -1, bad_stb = 0, trk = 0, mism = 0;
    while (cyc < 10) tick(1);
    pll_lock = 1'b1;
    for (int i = 0; i < LD + 200 && rise < 0; i++) begin
      tick(1);
      if (locked !== e_locked || rst_out_n !== e_locked) trk++;
      if (locked === 1'b1) rise = cyc;
      else if (strobe !== '0) bad_stb++;
    end
    checks++; if (rise != 10 + 2 + LD) begin errors++; $display("FAIL lock_rise_cycle: got %0d expected %0d", rise, 10 + 2 + LD); end
    checks++; if (bad_stb != 0) begin errors++; $display("FAIL strobe_before_lock: got %0d strobing cycles expected 0", bad_stb); end
    checks++; if (trk != 0) begin errors++; $display("FAIL lock_track: got %0d mismatches expected 0", trk); end
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (strobe !== e_strobe || locked !== 1'b1) mism++;
      if (first < 0 && strobe[0] === 1'b1) first = cyc;
    end
    // 4096/65536 -> 16 accumulates, the first one on the edge after release
    checks++; if (first != rise + 16) begin errors++; $display("FAIL first_strobe: got cycle %0d expected %0d", first, rise + 16); end
    checks++; if (mism != 0) begin errors++; $display("FAIL init_strobe_model: got %0d mismatches expected 0", mism); end
  endtask

  task automatic test_lock_loss();
    pll_lock = 1'b0;
    tick(2);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL loss_hold: got %b expected 1", locked); end
    tick(1);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL loss_locked: got %b expected 0", locked); end
    checks++; if (rst_out_n !== 1'b0) begin errors++; $display("FAIL loss_rst_out_n: got %b expected 0", rst_out_n); end
    checks++; if (strobe !== '0) begin errors++; $display("FAIL loss_strobe: got %b expected 0", strobe); end
`ifdef CLK_STROBE_GEN_LOSS_COUNT_EN
    checks++; if (lost_cnt !== 8'd1) begin errors++; $display("FAIL loss_count: got %0d expected 1", lost_cnt); end
`endif
  endtask

  task automatic test_rate();
    int c [NUM_CH] = '{default: 0};
    int inc2, rise = -1, last0 = -1, sp_err = 0, adj = 0, mism = 0;
    logic [NUM_CH-1:0] prev = '0;
    inc2 = $urandom_range(1, MOD - 1);
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_inc = 16'd16384; tick(1);
    cfg_ch = 2'd1; cfg_inc = 16'd21845; tick(1);
    cfg_ch = 2'd2; cfg_inc = inc2[ACC_W-1:0]; tick(1);
    cfg_we = 1'b0; pll_lock = 1'b1;
    for (int i = 0; i < LD + 50 && rise < 0; i++) begin
      tick(1);
      if (locked === 1'b1) rise = cyc;
    end
    checks++; if (rise < 0) begin errors++; $display("FAIL rate_lock_timeout: got no lock expected lock within %0d", LD + 50); end
    for (int i = 0; i < MOD; i++) begin
      tick(1);
      if (strobe !== e_strobe) mism++;
      for (int ch = 0; ch < NUM_CH; ch++) if (strobe[ch] === 1'b1) c[ch]++;
      if (strobe[0] === 1'b1) begin
        if (last0 >= 0 && i - last0 != 4) sp_err++;
        last0 = i;
      end
      if (strobe[1] === 1'b1 && prev[1] === 1'b1) adj++;
      prev = strobe;
    end
    checks++; if (c[0] != 16384) begin errors++; $display("FAIL rate_ch0_count: got %0d expected 16384", c[0]); end
    checks++; if (c[1] != 21845) begin errors++; $display("FAIL rate_ch1_count: got %0d expected 21845", c[1]); end
    checks++; if (c[2] != inc2) begin errors++; $display("FAIL rate_ch2_count: got %0d expected %0d", c[2], inc2); end
    checks++; if (sp_err != 0) begin errors++; $display("FAIL rate_ch0_spacing: got %0d bad gaps expected 0", sp_err); end
    checks++; if (adj != 0) begin errors++; $display("FAIL rate_ch1_adjacent: got %0d expected 0", adj); end
    checks++; if (mism != 0) begin errors++; $display("FAIL rate_model: got %0d mismatches expected 0", mism); end
  endtask

  task automatic test_write_collision();
    int z = 0, hits = 0, mism = 0;
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_inc = '0; tick(1); cfg_we = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (strobe[0] !== 1'b0) z++;
    end
    checks++; if (z != 0) begin errors++; $display("FAIL inc0_silent: got %0d strobes expected 0", z); end
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_inc = 16'hFFFF; tick(1); cfg_we = 1'b0;
    checks++; if (strobe[0] !== 1'b0) begin errors++; $display("FAIL collision_old_inc: got %b expected 0", strobe[0]); end
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (strobe[0] === 1'b1) hits++;
      if (strobe !== e_strobe) mism++;
    end
    checks++; if (hits < 3) begin errors++; $display("FAIL collision_new_inc: got %0d strobes in 4 expected >=3", hits); end
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_inc = 16'($urandom); tick(1); cfg_we = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (strobe !== e_strobe) mism++;
    end
    for (int i = 0; i < 400; i++) begin
      cfg_we  = ($urandom_range(0, 5) == 0);
      cfg_ch  = 2'($urandom_range(0, 3));
      cfg_inc = 16'($urandom);
      tick(1);
      if (strobe !== e_strobe) mism++;
    end
    cfg_we = 1'b0;
    checks++; if (mism != 0) begin errors++; $display("FAIL write_model: got %0d mismatches expected 0", mism); end
  endtask

  task automatic test_glitch();
    int g1, rise = -1, trk = 0;
    pll_lock = 1'b0;
    tick(4);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL glitch_setup: got %b expected 0", locked); end
`ifdef CLK_STROBE_GEN_LOSS_COUNT_EN
    checks++; if (lost_cnt !== 8'd2) begin errors++; $display("FAIL glitch_lost_cnt: got %0d expected 2", lost_cnt); end
`endif
    pll_lock = 1'b1;
    tick(502);
    pll_lock = 1'b0;
    tick(3);
    pll_lock = 1'b1;
    g1 = cyc;
    for (int i = 0; i < LD + 100 && rise < 0; i++) begin
      tick(1);
      if (locked !== e_locked) trk++;
      if (locked === 1'b1) rise = cyc;
    end
    checks++; if (rise != g1 + 2 + LD) begin errors++; $display("FAIL glitch_rise: got cycle %0d expected %0d", rise, g1 + 2 + LD); end
    checks++; if (trk != 0) begin errors++; $display("FAIL glitch_track: got %0d mismatches expected 0", trk); end
  endtask

  task automatic test_midrun_reset();
    int rise = -1, first = -1, mism = 0, uneq = 0;
    int c [NUM_CH] = '{default: 0};
    tick(50);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (locked !== 1'b0 || rst_out_n !== 1'b0) begin errors++; $display("FAIL midreset_lock: got %b/%b expected 0/0", locked, rst_out_n); end
    checks++; if (strobe !== '0) begin errors++; $display("FAIL midreset_strobe: got %b expected 0", strobe); end
`ifdef CLK_STROBE_GEN_LOSS_COUNT_EN
    checks++; if (lost_cnt !== 8'd0) begin errors++; $display("FAIL midreset_lost_cnt: got %0d expected 0", lost_cnt); end
`endif
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < LD + 50 && rise < 0; i++) begin
      tick(1);
      if (locked === 1'b1) rise = cyc;
    end
    checks++; if (rise != 2 + LD) begin errors++; $display("FAIL relock_rise: got cycle %0d expected %0d", rise, 2 + LD); end
    for (int i = 0; i < 512; i++) begin
      tick(1);
      if (strobe !== e_strobe) mism++;
      if (strobe !== '0 && strobe !== '1) uneq++;
      if (first < 0 && strobe[0] === 1'b1) first = cyc;
      for (int ch = 0; ch < NUM_CH; ch++) if (strobe[ch] === 1'b1) c[ch]++;
    end
    checks++; if (first != rise + 16) begin errors++; $display("FAIL relock_first_strobe: got cycle %0d expected %0d", first, rise + 16); end
    for (int ch = 0; ch < NUM_CH; ch++) begin
      checks++; if (c[ch] != 32) begin errors++; $display("FAIL relock_inc_init ch%0d: got %0d strobes expected 32", ch, c[ch]); end
    end
    checks++; if (uneq != 0 || mism != 0) begin errors++; $display("FAIL relock_model: got %0d/%0d mismatches expected 0", uneq, mism); end
  endtask

`ifdef CLK_STROBE_GEN_LOSS_COUNT_EN
  task automatic test_loss_saturate();
    int to = 0;
    for (int ev = 1; ev <= 300; ev++) begin
      lock2 = 1'b1;
      for (int k = 0; k < 20 && locked2 !== 1'b1; k++) tick(1);
      if (locked2 !== 1'b1) to++;
      lock2 = 1'b0;
      for (int k = 0; k < 20 && locked2 !== 1'b0; k++) tick(1);
      if (locked2 !== 1'b0) to++;
      if (ev == 1) begin
        checks++; if (lost2 !== 8'd1) begin errors++; $display("FAIL sat_first: got %0d expected 1", lost2); end
      end
    end
    checks++; if (to != 0) begin errors++; $display("FAIL sat_timeout: got %0d timeouts expected 0", to); end
    checks++; if (lost2 !== 8'd255) begin errors++; $display("FAIL sat_final: got %0d expected 255", lost2); end
  endtask
`endif

  initial begin
    test_reset();
    test_lock_release();
    test_lock_loss();
    test_rate();
    test_write_collision();
    test_glitch();
    test_midrun_reset();
`ifdef CLK_STROBE_GEN_LOSS_COUNT_EN
    test_loss_saturate();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
